// File: rtl/mtm_alu_deserializer.sv
// Serial front end of the ALU datapath: assembles 8 data bytes + 1 command byte into a, b, ctl.
// Optional partial-packet idle timeout when DESER_TIMEOUT_EN is defined (TIMEOUT_CYC cycles).
module mtm_alu_deserializer
`ifdef DESER_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYC = 2000)
`endif
  (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [7:0]  ctl,
  output logic        valid,
  output logic        err,
  output logic [2:0]  err_flags
);

  typedef enum logic [1:0] {S_IDLE, S_TYPE, S_DATA, S_STOP} state_e;

  state_e      state_q, state_d;
  logic        type_q, type_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [63:0] pkt_q, pkt_d;
  logic        need_high_q, need_high_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [7:0]  ctl_q, ctl_d;
  logic        valid_q, valid_d, err_q, err_d;
  logic [2:0]  flags_q, flags_d;

  logic [2:0]  op;
  logic [3:0]  crc_calc;
  logic        crc_bad, op_bad;
  logic [2:0]  pkt_flags;

`ifdef DESER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] idle_cnt_q, idle_cnt_d;
`endif

  // Serial CRC4, poly x^4+x+1, init 0, MSB of the message first.
  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  assign op       = shift_q[6:4];
  assign crc_calc = crc4({pkt_q, 1'b1, op});
  assign crc_bad  = (crc_calc != shift_q[3:0]);
  assign op_bad   = !((op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b101));
  assign pkt_flags = (byte_cnt_q != 4'd8) ? 3'b100 : {1'b0, crc_bad, op_bad};

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    pkt_d       = pkt_q;
    need_high_d = need_high_q;
    a_d         = a_q;
    b_d         = b_q;
    ctl_d       = ctl_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    flags_d     = 3'b000;
`ifdef DESER_TIMEOUT_EN
    idle_cnt_d  = idle_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        // After a framing error the line must return high before a new start bit counts.
        if (need_high_q) begin
          if (sin) need_high_d = 1'b0;
        end else if (!sin) begin
          state_d = S_TYPE;
        end
      end
      S_TYPE: begin
        type_d    = sin;
        bit_cnt_d = 3'd0;
        state_d   = S_DATA;
      end
      S_DATA: begin
        shift_d   = {shift_q[6:0], sin};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = S_STOP;
      end
      S_STOP: begin
        state_d = S_IDLE;
        if (!sin) begin
          err_d       = 1'b1;
          flags_d     = 3'b100;
          byte_cnt_d  = 4'd0;
          need_high_d = 1'b1;
        end else if (!type_q) begin
          if (byte_cnt_q < 4'd8) pkt_d = {pkt_q[55:0], shift_q};
          if (byte_cnt_q != 4'd9) byte_cnt_d = byte_cnt_q + 4'd1;
        end else begin
          byte_cnt_d = 4'd0;
          if (pkt_flags == 3'b000) begin
            valid_d = 1'b1;
            b_d     = pkt_q[63:32];
            a_d     = pkt_q[31:0];
            ctl_d   = {1'b0, shift_q[6:0]};
          end else begin
            err_d   = 1'b1;
            flags_d = pkt_flags;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef DESER_TIMEOUT_EN
    if (state_q == S_IDLE && !need_high_q && !sin) begin
      idle_cnt_d = 16'd0;
    end else if (state_q == S_IDLE && byte_cnt_q != 4'd0 && byte_cnt_q < 4'd9 && sin) begin
      if (idle_cnt_q == TIMEOUT_LAST) begin
        idle_cnt_d = 16'd0;
        byte_cnt_d = 4'd0;
        err_d      = 1'b1;
        flags_d    = 3'b100;
      end else begin
        idle_cnt_d = idle_cnt_q + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      type_q      <= 1'b0;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 4'd0;
      shift_q     <= 8'd0;
      pkt_q       <= 64'd0;
      need_high_q <= 1'b0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      ctl_q       <= 8'd0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      flags_q     <= 3'b000;
`ifdef DESER_TIMEOUT_EN
      idle_cnt_q  <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      pkt_q       <= pkt_d;
      need_high_q <= need_high_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctl_q       <= ctl_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      flags_q     <= flags_d;
`ifdef DESER_TIMEOUT_EN
      idle_cnt_q  <= idle_cnt_d;
`endif
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign ctl       = ctl_q;
  assign valid     = valid_q;
  assign err       = err_q;
  assign err_flags = flags_q;

endmodule
